regout_seq_ctrl: RTL
====================

// Module: regout_seq_ctrl
// PURPOSE
//  Controller for the NPU result shift chain (DEPTH x N-bit registers, byte-wide readout).
//  Replaces gated/button-muxed chain clocking with a single-clock enable scheme:
//  fills the chain from the NPU core, then drains it one byte at a time to the 8-bit display/host port.
//  Drain advances by valid/ready handshake (auto mode) or by debounced push-button edges (manual mode).
// PARAMETERS
//  N       32   result word width; must be a multiple of 8
//  DEPTH   11   number of words in the result chain
//  BYTES   N/8  bytes per word (derived, not overridable)
// PORTS
//  clk        in   1      single system clock; all logic on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      pulse: begin fill+drain sequence (ignored while busy)
//  abort      in   1      synchronous return to IDLE
//  s          in   1      mode: 0 = auto handshake, 1 = manual buttons; latched on accepted start
//  p_button   in   1      async push-button: manual word skip
//  s_button   in   1      async push-button: manual byte step
//  in_valid   in   1      NPU core presents a result word to chain head
//  in_ready   out  1      chain accepts a word this cycle
//  tail_word  in   N      word currently at chain tail
//  shift_en   out  1      chain shift enable (one-cycle strobe per shift)
//  chain_zero out  1      1 = chain head input forced to zero (drain shifts)
//  out_byte   out  8      selected byte of tail_word, MSB byte first
//  out_valid  out  1      out_byte is valid
//  out_ready  in   1      consumer accepts out_byte (auto mode only)
//  byte_idx   out  2      byte index presented (0 = bits N-1:N-8)
//  word_idx   out  4      words drained so far in this sequence
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse after final byte accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, mode latch 0, sync flops 0.
//  States: IDLE -> FILL -> DRAIN -> (SHIFT -> DRAIN)* -> FIN -> IDLE.
//  IDLE: start=1 -> FILL next cycle; latch s into mode. start with busy=1 has no effect.
//  FILL: in_ready=1; shift_en = in_valid; fill_cnt++ per accepted word;
//        on DEPTH-th accepted word -> DRAIN next cycle (no extra shift).
//  DRAIN: out_valid=1, out_byte = tail_word[N-1-8*byte_idx -: 8].
//    advance event: auto = out_valid & out_ready; manual = s_button rising edge (synchronised).
//    on advance with byte_idx<BYTES-1: byte_idx++.
//    on advance with byte_idx==BYTES-1: byte_idx<=0, word_idx++; if word_idx==DEPTH-1 -> FIN else SHIFT.
//    manual p_button edge: skip rest of word, same as advance at last byte; p wins over s same cycle.
//    buttons ignored in auto mode; out_ready ignored in manual mode.
//  SHIFT: one cycle, shift_en=1, chain_zero=1, out_valid=0 -> DRAIN.
//  FIN: done=1 for one cycle, out_valid=0 -> IDLE; word_idx holds until next start, then clears.
//  abort (any state, highest priority after reset): -> IDLE next cycle, counters clear, no done,
//    shift_en=0 that cycle; chain contents untouched.
//  Buttons: 2-flop synchroniser + rising-edge detect; edge usable 3 cycles after pad rise;
//    edges outside DRAIN discarded (no queueing). Held button yields one event.
//  Throughput auto mode, out_ready=1: one byte/cycle, plus 1 SHIFT cycle per word:
//    DEPTH*(BYTES+1)-1 cycles from DRAIN entry to FIN.
//  Counters saturate-free: widths sized by clog2(DEPTH+1), clog2(BYTES); no wrap in legal flow.
// STRUCTURE
//  Package regout_pkg: state enum (IDLE,FILL,DRAIN,SHIFT,FIN), default N/DEPTH, BYTES,
//    counter width localparams, byte-slice helper function.
//  Sub-module btn_sync_edge (async in -> 2FF sync -> 1-cycle rise pulse), instantiated for
//    p_button and s_button. FSM, counters and byte mux live in regout_seq_ctrl.
// TESTING
//  1 Reset mid-DRAIN (rst_n low 1 cycle) -> all outputs 0, IDLE, byte_idx=0, word_idx=0.
//  2 Auto, out_ready=1, words 0x11223344.. fed with in_valid=1 -> bytes 11,22,33,44 per word,
//    11 SHIFT strobes minus 1 = 10, done pulse exactly once, 54 cycles DRAIN->FIN.
//  3 Auto, out_ready toggling 1010.. -> out_byte stable while out_valid & !out_ready; no byte lost.
//  4 Manual: s_button pulses x2 then p_button -> bytes 0,1 shown then word_idx=1 after SHIFT;
//    p and s same cycle -> word skip only.
//  5 FILL with in_valid gaps (3 of 11 cycles low) -> exactly 11 shift_en in FILL; start during DRAIN ignored.
//  6 abort in SHIFT -> IDLE next cycle, shift_en=0, no done; new start refills from fill_cnt=0.

Source files
------------

// File: rtl/regout_pkg.sv
// Shared types and helpers for the result-chain readout controller.
package regout_pkg;

  localparam int unsigned DefaultN     = 32;
  localparam int unsigned DefaultDepth = 11;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StDrain,
    StShift,
    StFin
  } state_e;

  // Width of a counter that must hold values 0..range-1 (at least one bit).
  function automatic int unsigned cnt_width(int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  // Left-shift amount that brings byte idx (0 = most significant) to the top of a word.
  function automatic int unsigned byte_shift(int unsigned idx);
    return 8 * idx;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Asynchronous push-button input: two-flop synchroniser followed by rising-edge detect.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  // [0] and [1] form the synchroniser, [2] remembers the previous synchronised level.
  logic [2:0] sync_q;

  // Shift the pad level through the synchroniser and edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], btn_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/regout_seq_ctrl.sv
// Fill/drain sequencer for the NPU result shift chain with byte-wide readout.
module regout_seq_ctrl
  import regout_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         s,
  input  logic         p_button,
  input  logic         s_button,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] tail_word,
  output logic         shift_en,
  output logic         chain_zero,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   byte_idx,
  output logic [3:0]   word_idx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned BYTES = N / 8;
  localparam int unsigned CntW  = cnt_width(DEPTH + 1);
  localparam int unsigned ByteW = cnt_width(BYTES);

  localparam logic [CntW-1:0]  LastWord = CntW'(DEPTH - 1);
  localparam logic [ByteW-1:0] LastByte = ByteW'(BYTES - 1);

  state_e           state_q;
  logic             mode_q;
  logic [CntW-1:0]  fill_q;
  logic [CntW-1:0]  word_q;
  logic [ByteW-1:0] byte_q;

  logic p_rise, s_rise;
  logic last_byte, step_byte, step_word;
  logic [N-1:0] shifted;

  btn_sync_edge u_p_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (p_button),
    .rise_o (p_rise)
  );

  btn_sync_edge u_s_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (s_button),
    .rise_o (s_rise)
  );

  // Decode the drain advance events; p wins over s so a combined press only skips the word.
  always_comb begin
    last_byte = (byte_q == LastByte);
    step_byte = 1'b0;
    step_word = 1'b0;
    if (mode_q) begin
      step_word = p_rise | (s_rise & last_byte);
      step_byte = ~p_rise & s_rise & ~last_byte;
    end else begin
      step_word = out_ready & last_byte;
      step_byte = out_ready & ~last_byte;
    end
  end

  // Sequencer state, mode latch and fill/byte/word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      word_q  <= '0;
      byte_q  <= '0;
    end else if (abort) begin
      state_q <= StIdle;
      fill_q  <= '0;
      word_q  <= '0;
      byte_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFill;
            mode_q  <= s;
            fill_q  <= '0;
            word_q  <= '0;
            byte_q  <= '0;
          end
        end
        StFill: begin
          if (in_valid) begin
            fill_q <= fill_q + 1'b1;
            if (fill_q == LastWord) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (step_word) begin
            byte_q  <= '0;
            word_q  <= word_q + 1'b1;
            state_q <= (word_q == LastWord) ? StFin : StShift;
          end else if (step_byte) begin
            byte_q <= byte_q + 1'b1;
          end
        end
        StShift: state_q <= StDrain;
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bring the selected byte to the top of the word; byte 0 is the most significant.
  assign shifted = tail_word << byte_shift(32'(byte_q));

  // Outputs decoded from the registered state; abort suppresses shifts, fill handshake and done.
  always_comb begin
    in_ready   = (state_q == StFill) & ~abort;
    shift_en   = ~abort & (((state_q == StFill) & in_valid) | (state_q == StShift));
    chain_zero = (state_q == StShift);
    out_valid  = (state_q == StDrain);
    out_byte   = out_valid ? shifted[N-1 -: 8] : 8'h00;
    byte_idx   = 2'(byte_q);
    word_idx   = 4'(word_q);
    busy       = (state_q != StIdle);
    done       = (state_q == StFin) & ~abort;
  end

endmodule
